// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline definitions: datapath widths, stall-sequencer state encodings and defaults.
package pipe_stall_ctrl_pkg;

  localparam int unsigned ASIZE_DEF      = 5;
  localparam int unsigned DSIZE_DEF      = 32;
  localparam int unsigned ISIZE_DEF      = 32;
  localparam int unsigned DM_TIMEOUT_DEF = 15;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned WAIT_CNT_W     = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the ID instruction's sources and a load in EX.
module hazard_detect #(
  parameter int unsigned ASIZE = 5
) (
  input  logic [ASIZE-1:0] rs_addr,
  input  logic [ASIZE-1:0] rt_addr,
  input  logic             rs_used,
  input  logic             rt_used,
  input  logic             mem_read,
  input  logic [ASIZE-1:0] waddr,
  output logic             load_use
);

  always_comb begin
    load_use = 1'b0;
    // r0 is hard-wired zero, so a load targeting it never creates a dependency
    if (mem_read && (waddr != '0)) begin
      load_use = (rs_used && (rs_addr == waddr)) ||
                 (rt_used && (rt_addr == waddr));
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline with data-memory watchdog.
// Optional stall statistics counter enabled by defining STALL_STATS_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned ASIZE      = ASIZE_DEF,
  parameter int unsigned DM_TIMEOUT = DM_TIMEOUT_DEF
`ifdef STALL_STATS_EN
  ,
  parameter int unsigned CNT_W      = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ASIZE-1:0] rs_addr_id,
  input  logic [ASIZE-1:0] rt_addr_id,
  input  logic             rs_used_id,
  input  logic             rt_used_id,
  input  logic             memRead_id_ex,
  input  logic [ASIZE-1:0] waddr_id_ex,
  input  logic             branch_taken_ex,
  input  logic             dm_req_mem,
  input  logic             dm_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_bubble,
  output logic             dm_err
`ifdef STALL_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = DM_TIMEOUT[WAIT_CNT_W-1:0];

  state_t                  state, state_next;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    load_use;
  logic                    mem_stall;

  hazard_detect #(.ASIZE(ASIZE)) u_hazard_detect (
    .rs_addr  (rs_addr_id),
    .rt_addr  (rt_addr_id),
    .rs_used  (rs_used_id),
    .rt_used  (rt_used_id),
    .mem_read (memRead_id_ex),
    .waddr    (waddr_id_ex),
    .load_use (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN:      if (dm_req_mem && !dm_ready) state_next = MEM_WAIT;
      MEM_WAIT: begin
        if (dm_ready)                      state_next = RUN;
        else if (wait_cnt == TIMEOUT_CNT)  state_next = TRAP;
      end
      TRAP:     state_next = TRAP;
      default:  state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == RUN && state_next == MEM_WAIT) begin
      wait_cnt <= '0;
    end else if (state == MEM_WAIT && wait_cnt != TIMEOUT_CNT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   dm_err <= 1'b0;
    else if (state != TRAP && state_next == TRAP) dm_err <= 1'b1;
  end

  always_comb begin
    mem_stall = 1'b0;
    unique case (state)
      RUN:      mem_stall = dm_req_mem && !dm_ready;
      MEM_WAIT: mem_stall = !dm_ready;
      TRAP:     mem_stall = 1'b1;
      default:  mem_stall = 1'b0;
    endcase
  end

  // Held in reset the pipeline sees plain run controls regardless of inputs
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      if (mem_stall) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (branch_taken_ex) begin
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
      end else if (load_use) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_flush   = 1'b1;
      end
    end
  end

`ifdef STALL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if ((mem_stall || load_use) && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: table-driven combinational vectors plus multi-cycle sequences.
module tb_pipe_stall_ctrl;

  localparam int unsigned ASIZE = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic [ASIZE-1:0] rs_addr_id, rt_addr_id, waddr_id_ex;
  logic             rs_used_id, rt_used_id, memRead_id_ex;
  logic             branch_taken_ex, dm_req_mem, dm_ready;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic             if_id_flush, id_ex_flush, mem_wb_bubble, dm_err;
`ifdef STALL_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.ASIZE(ASIZE), .DM_TIMEOUT(15)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs_addr_id      (rs_addr_id),
    .rt_addr_id      (rt_addr_id),
    .rs_used_id      (rs_used_id),
    .rt_used_id      (rt_used_id),
    .memRead_id_ex   (memRead_id_ex),
    .waddr_id_ex     (waddr_id_ex),
    .branch_taken_ex (branch_taken_ex),
    .dm_req_mem      (dm_req_mem),
    .dm_ready        (dm_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .mem_wb_bubble   (mem_wb_bubble),
    .dm_err          (dm_err)
`ifdef STALL_STATS_EN
    ,
    .stall_cnt       (stall_cnt)
`endif
  );

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble}
  localparam logic [6:0] O_NORM  = 7'b1111_000;
  localparam logic [6:0] O_LU    = 7'b0011_010;
  localparam logic [6:0] O_BR    = 7'b1111_110;
  localparam logic [6:0] O_MSTL  = 7'b0000_001;

  logic [6:0] outs;
  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};

  typedef struct {
    string            name;
    logic [ASIZE-1:0] rs, rt, wa;
    logic             rsu, rtu, mr, br, req, rdy;
    logic [6:0]       exp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [6:0] exp);
    tests++;
    if (outs !== exp) begin
      fails++;
      $display("FAIL %s: outputs got %b expected %b", name, outs, exp);
    end
  endtask

  task automatic chk_err(input string name, input logic exp);
    tests++;
    if (dm_err !== exp) begin
      fails++;
      $display("FAIL %s: dm_err got %b expected %b", name, dm_err, exp);
    end
  endtask

  task automatic drive(input logic [ASIZE-1:0] rs, rt, wa,
                       input logic rsu, rtu, mr, br, req, rdy);
    rs_addr_id = rs; rt_addr_id = rt; waddr_id_ex = wa;
    rs_used_id = rsu; rt_used_id = rtu; memRead_id_ex = mr;
    branch_taken_ex = br; dm_req_mem = req; dm_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{"normal",       5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[1] = '{"lu_rs",        5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[2] = '{"lu_zero_reg",  5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[3] = '{"rs_not_used",  5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[4] = '{"lu_rt",        5'd1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
    vecs[5] = '{"no_load",      5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[6] = '{"branch_lu",    5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[7] = '{"branch_only",  5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, O_BR};
    vecs[8] = '{"dm_hit_norm",  5'd3, 5'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_NORM};
    vecs[9] = '{"dm_hit_lu",    5'd3, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, O_LU};

    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #2;
    chk("reset_outputs", O_NORM);
    chk_err("reset_dm_err", 1'b0);
    #10;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].wa, vecs[i].rsu, vecs[i].rtu,
            vecs[i].mr, vecs[i].br, vecs[i].req, vecs[i].rdy);
      #2;
      chk(vecs[i].name, vecs[i].exp);
      tick();
    end

    // Load-use releases once the load moves on and a bubble sits in EX
    drive(5'd5, '0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2; chk("lu_seq_stall", O_LU);
    tick();
    drive(5'd5, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2; chk("lu_seq_release", O_NORM);
    tick();

    // Three-cycle memory wait, advance on the fourth
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #2; chk($sformatf("mw_stall%0d", c), O_MSTL);
      tick();
    end
    dm_ready = 1'b1;
    #2; chk("mw_advance", O_NORM);
    tick();
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2; chk("mw_back_run", O_NORM);
    tick();

    // Watchdog: hung memory traps after the wait counter hits the limit
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 16; c++) tick();
    chk_err("wd_not_yet", 1'b0);
    chk("wd_wait_stall", O_MSTL);
    tick();
    chk_err("wd_trapped", 1'b1);
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    #2; chk("trap_absorbing", O_MSTL);
    chk_err("trap_sticky", 1'b1);
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk_err("trap_async_rst", 1'b0);
    chk("trap_rst_outputs", O_NORM);
    #2;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    #2; chk("after_trap_run", O_NORM);
    tick();

    // dm_ready on the timeout cycle wins over the trap
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 16; c++) tick();
    dm_ready = 1'b1;
    #2; chk("to_ready_advance", O_NORM);
    tick();
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2; chk("to_ready_run", O_NORM);
    chk_err("to_ready_no_err", 1'b0);
    tick();

`ifdef STALL_STATS_EN
    do_reset();
    drive(5'd5, '0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) tick();
    dm_ready = 1'b1;
    tick();
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if (stall_cnt !== 16'd4) begin
      fails++;
      $display("FAIL stall_cnt: got %0d expected 4", stall_cnt);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (stall_cnt !== 16'd0) begin
      fails++;
      $display("FAIL stall_cnt_rst: got %0d expected 0", stall_cnt);
    end
    #2;
    rst = 1'b1;
`else
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central hazard/stall sequencer for the 5-stage pipeline: drives enable, flush and bubble controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use hazards, taken-branch/jal flushes and variable-latency data-memory waits, with a watchdog that traps a hung memory.
- Sits beside the datapath; all stage registers take their enable/flush from this block.

Parameters:
- ASIZE, 5, register-address width (matches `ASIZE).
- DM_TIMEOUT, 15, max consecutive data-memory wait cycles before error trap; legal 1..255.
- CNT_W, 16, width of stall statistics counter (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous reset, active-low.
- rs_addr_id  in  ASIZE  source-1 register of instruction in ID.
- rt_addr_id  in  ASIZE  source-2 register of instruction in ID.
- rs_used_id  in  1  ID instruction reads rs.
- rt_used_id  in  1  ID instruction reads rt.
- memRead_id_ex  in  1  instruction in EX is a load.
- waddr_id_ex  in  ASIZE  destination of instruction in EX.
- branch_taken_ex  in  1  branch/jal redirect resolved in EX.
- dm_req_mem  in  1  MEM-stage instruction accesses data memory.
- dm_ready  in  1  data memory completes access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register capture enables.
- if_id_flush, id_ex_flush  out  1 each  load NOP into register at next edge.
- mem_wb_bubble  out  1  MEM/WB captures with WriteEn forced 0.
- dm_err  out  1  sticky watchdog error.

Behaviour:
- FSM states: RUN, MEM_WAIT, TRAP; state register reset to RUN asynchronously when rst=0. dm_err is a registered flag, reset 0; all other outputs are combinational from state and inputs.
- mem_stall = (RUN and dm_req_mem and not dm_ready) or (MEM_WAIT and not dm_ready) or TRAP.
- load_use = memRead_id_ex and waddr_id_ex != 0 and ((rs_used_id and rs_addr_id == waddr_id_ex) or (rt_used_id and rt_addr_id == waddr_id_ex)).
- Priority: mem_stall > branch_taken_ex > load_use > normal.
- mem_stall: pc_en, if_id_en, id_ex_en, ex_mem_en = 0; no flushes; mem_wb_bubble = 1. Branch and load-use are ignored because upstream is frozen and its inputs are held.
- branch_taken_ex (no mem_stall): all enables 1; if_id_flush = id_ex_flush = 1; load_use is ignored (wrong-path instruction).
- load_use (no mem_stall, no branch): pc_en = if_id_en = 0; id_ex_en = 1 with id_ex_flush = 1; ex_mem_en = 1. This is a one-cycle bubble; it releases the next cycle when the load has moved to MEM.
- normal: all enables 1; flushes and bubble 0.
- Transitions:
  - RUN -> MEM_WAIT when dm_req_mem and not dm_ready.
  - MEM_WAIT -> RUN on dm_ready. Stall drops in the same cycle, so the pipeline advances at that edge.
  - MEM_WAIT -> TRAP when the wait counter reaches DM_TIMEOUT and dm_ready = 0.
  - TRAP is absorbing until reset.
- Wait counter: 8-bit, reset 0. Cleared on entering MEM_WAIT, then increments each MEM_WAIT cycle, with no wrap (saturates at DM_TIMEOUT). dm_ready in the same cycle as the timeout has priority: go to RUN, no trap.
- dm_err is set on entry to TRAP and cleared only by reset.
- Reset mid-wait: FSM returns to RUN and the counter clears immediately; outputs go to normal values while rst=0.

Optional Feature:
- Macro STALL_STATS_EN.
- Defined: adds output stall_cnt [CNT_W-1:0], reset 0, incremented every cycle mem_stall or load_use is asserted; saturates at all-ones.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/define file holds the FSM state encodings (RUN=2'd0, MEM_WAIT=2'd1, TRAP=2'd2) and the default DM_TIMEOUT, next to the existing ASIZE/DSIZE/ISIZE defines.
- One natural sub-module: hazard_detect. It is purely combinational load_use compare, reusable by the forwarding unit.

Test Plan:
- Load-use: memRead_id_ex=1, waddr_id_ex=5, rs_addr_id=5, rs_used_id=1 -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1.
- Zero register: same as above but waddr_id_ex=0 -> no stall.
- Branch plus load-use in the same cycle: branch_taken_ex=1 with load_use true -> if_id_flush=id_ex_flush=1, pc_en=1.
- Memory wait: dm_req_mem=1, dm_ready low for 3 cycles then high -> 3 cycles of all enables 0 with mem_wb_bubble=1; advance on the 4th cycle; FSM back in RUN.
- Watchdog: dm_ready never asserted, DM_TIMEOUT=15 -> TRAP entered, dm_err=1, enables stay 0. Assert rst=0 mid-trap -> dm_err=0 asynchronously, state RUN.
- STALL_STATS_EN: 1 load-use stall plus 3 memory-wait cycles -> stall_cnt=4; rst=0 clears it to 0.
